dmem_responder: RTL and testbench

Handshaked, multi-cycle data-memory responder: the target end of the hart's load/store port, replacing the single-cycle data memory once the pipeline stalls on memory. Accepts one request at a time over a valid/ready channel, waits a fixed latency, performs a sized RV64 load or store on an internal dword array, and returns data and error status over a second valid/ready channel.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_responder_if.sv | 33 +++
 rtl/dmem_lane_align.sv | 76 +++++++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg : shared funct3 codes, FSM state encoding and widths for dmem_responder
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  localparam int DWORD_BITS = 64;
  localparam int DWORD_BYTES = DWORD_BITS / 8;

  // Load size/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store size codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Byte-enable pattern for an access of the given size code, before shifting
  function automatic logic [DWORD_BYTES-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if : request/response valid-ready channels of the data memory port
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [2:0]  req_funct3;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align : byte-lane steering for sized RV64 loads/stores.
// DMEM_MISALIGN_CHECK_EN keeps the raw offset (caller faults); else offset is aligned down.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]            offset,
  input  logic [2:0]            funct3,
  input  logic                  we,
  input  logic [DWORD_BITS-1:0] wdata,
  input  logic [DWORD_BITS-1:0] rd_dword,
  output logic [7:0]            wmask,
  output logic [DWORD_BITS-1:0] wdata_shifted,
  output logic [DWORD_BITS-1:0] load_data,
  output logic                  size_err,
  output logic                  misalign
);

  logic [1:0]            w_size;
  logic [2:0]            w_eff_off;
  logic [5:0]            w_bit_shift;
  logic [DWORD_BITS-1:0] w_raw;

  assign w_size = funct3[1:0];

  always_comb begin
    misalign = 1'b0;
    case (w_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = offset[0];
      2'd2:    misalign = |offset[1:0];
      default: misalign = |offset;
    endcase
  end

  always_comb begin
    w_eff_off = offset;
`ifndef DMEM_MISALIGN_CHECK_EN
    case (w_size)
      2'd0:    w_eff_off = offset;
      2'd1:    w_eff_off = {offset[2:1], 1'b0};
      2'd2:    w_eff_off = {offset[2], 2'b00};
      default: w_eff_off = 3'b000;
    endcase
`endif
  end

  assign w_bit_shift   = {w_eff_off, 3'b000};
  assign wmask         = size_mask(w_size) << w_eff_off;
  assign wdata_shifted = wdata << w_bit_shift;
  assign w_raw         = rd_dword >> w_bit_shift;

  // Stores have no unsigned variants, so every funct3 with bit 2 set is invalid
  assign size_err = we ? funct3[2] : (funct3 == 3'b111);

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{56{w_raw[7]}},  w_raw[7:0]};
      F3_LH:   load_data = {{48{w_raw[15]}}, w_raw[15:0]};
      F3_LW:   load_data = {{32{w_raw[31]}}, w_raw[31:0]};
      F3_LD:   load_data = w_raw;
      F3_LBU:  load_data = {56'd0, w_raw[7:0]};
      F3_LHU:  load_data = {48'd0, w_raw[15:0]};
      F3_LWU:  load_data = {32'd0, w_raw[31:0]};
      default: load_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder : handshaked fixed-latency RV64 data memory (FSM, counter, array).
// Optional DMEM_MISALIGN_CHECK_EN faults misaligned accesses.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int DEPTH    = 2 ** (ADDR_BITS - 3);
  localparam int IDX_BITS = (ADDR_BITS > 3) ? (ADDR_BITS - 3) : 1;
  localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]            r_state;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  r_we;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [2:0]            r_funct3;
  logic [DWORD_BITS-1:0] r_wdata;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [DWORD_BITS-1:0] r_rdata;
  logic                  r_err;

  logic [DWORD_BITS-1:0] r_mem [DEPTH];

  logic [IDX_BITS-1:0]   w_idx;
  logic [DWORD_BITS-1:0] w_rd_dword;
  logic [7:0]            w_wmask;
  logic [DWORD_BITS-1:0] w_wdata_sh;
  logic [DWORD_BITS-1:0] w_load_data;
  logic                  w_size_err;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_access;
  logic                  w_do_write;

  generate
    if (ADDR_BITS > 3) begin : g_idx_multi
      assign w_idx = r_addr[ADDR_BITS-1:3];
    end else begin : g_idx_single
      assign w_idx = '0;
    end
  endgenerate

  generate
    if (ADDR_BITS < 64) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.req_addr[63:ADDR_BITS];
    end
  endgenerate

  assign w_rd_dword = r_mem[w_idx];

  dmem_lane_align u_lane_align (
    .offset        (r_addr[2:0]),
    .funct3        (r_funct3),
    .we            (r_we),
    .wdata         (r_wdata),
    .rd_dword      (w_rd_dword),
    .wmask         (w_wmask),
    .wdata_shifted (w_wdata_sh),
    .load_data     (w_load_data),
    .size_err      (w_size_err),
    .misalign      (w_misalign)
  );

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_err = w_size_err | w_misalign;
`else
  logic unused_misalign;
  assign unused_misalign = w_misalign;
  assign w_err           = w_size_err;
`endif

  assign w_access   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_do_write = w_access && r_we && !w_err;

  // Reset on the access edge wins: the in-flight store is dropped unwritten
  always_ff @(posedge clk) begin
    if (!reset && w_do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (w_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr[ADDR_BITS-1:0];
            r_funct3    <= bus.req_funct3;
            r_wdata     <= bus.req_wdata;
            r_cnt       <= CNT_LOAD;
            r_state     <= S_WAIT;
            r_req_ready <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
            r_rdata      <= (r_we || w_err) ? '0 : w_load_data;
          end else begin
            r_cnt <= r_cnt - CNT_BITS'(1);
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder : directed plus random load/store sequence against a byte-array model
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

  localparam int ADDR_BITS = 12;
  localparam int LATENCY   = 2;
  localparam int MEM_BYTES = 1 << ADDR_BITS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_BITS (ADDR_BITS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mm [0:MEM_BYTES-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed memory with sized, extended accesses
  task automatic model(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                       input logic [63:0] wdata, output logic [63:0] rd, output logic er);
    int size;
    int a;
    logic [63:0] v;
    logic [63:0] ones;
    size = 1 << f3[1:0];
    a    = int'(addr[ADDR_BITS-1:0]);
    er   = we ? f3[2] : (f3 == 3'b111);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((a % size) != 0) er = 1'b1;
`else
    a = a - (a % size);
`endif
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) mm[a+i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mm[a+i];
        if (!f3[2] && size < 8 && v[8*size-1]) begin
          ones = '1;
          v    = v | (ones << (8*size));
        end
        rd = v;
      end
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [63:0] addr,
                        input logic [2:0] f3, input logic [63:0] wdata, input int hold,
                        output logic [63:0] rd, output logic er);
    logic [63:0] exp_rd;
    logic        exp_er;
    int k;
    model(we, addr, f3, wdata, exp_rd, exp_er);
    @(negedge clk);
    check({tag, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_addr   = {$urandom, $urandom};
    bus.req_funct3 = 3'($urandom);
    bus.req_wdata  = {$urandom, $urandom};
    k = 0;
    while (!bus.resp_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(LATENCY));
    rd = bus.resp_rdata;
    er = bus.resp_err;
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " err"}, 64'(er), 64'(exp_er));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, " hold rdata"}, bus.resp_rdata, exp_rd);
      check({tag, " hold req_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({tag, " retire req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, " retire valid"}, 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    logic        e;
    logic [63:0] a;

    reset          = 1'b1;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 64'h10;
    bus.req_funct3 = 3'b011;
    bus.req_wdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(bus.req_ready), 64'd1);
    check("reset resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset rdata", bus.resp_rdata, 64'd0);
    check("reset err", 64'(bus.resp_err), 64'd0);
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post-reset nothing latched", 64'(bus.resp_valid), 64'd0);

    do_req("sd 0x10", 1'b1, 64'h10, 3'b011, 64'h1122334455667788, 0, r, e);
    do_req("ld 0x10", 1'b0, 64'h10, 3'b011, 64'h0, 0, r, e);
    check("ld 0x10 const", r, 64'h1122334455667788);
    do_req("sb 0x13", 1'b1, 64'h13, 3'b000, 64'hAAAAAAAAAAAAAA80, 0, r, e);
    do_req("lb 0x13", 1'b0, 64'h13, 3'b000, 64'h0, 0, r, e);
    check("lb 0x13 const", r, 64'hFFFFFFFFFFFFFF80);
    do_req("lbu 0x13", 1'b0, 64'h13, 3'b100, 64'h0, 0, r, e);
    check("lbu 0x13 const", r, 64'h80);
    do_req("ld hold", 1'b0, 64'h10, 3'b011, 64'h0, 5, r, e);
    check("ld hold const", r, 64'h1122334480667788);

    do_req("st f3=100", 1'b1, 64'h10, 3'b100, 64'h5555555555555555, 0, r, e);
    check("st f3=100 err", 64'(e), 64'd1);
    do_req("ld f3=111", 1'b0, 64'h10, 3'b111, 64'h0, 0, r, e);
    check("ld f3=111 err", 64'(e), 64'd1);
    do_req("ld after err", 1'b0, 64'h10, 3'b011, 64'h0, 0, r, e);
    check("ld after err const", r, 64'h1122334480667788);

    do_req("lw 0x12", 1'b0, 64'h12, 3'b010, 64'h0, 0, r, e);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("lw 0x12 err const", 64'(e), 64'd1);
`else
    check("lw 0x12 const", r, 64'hFFFFFFFF80667788);
`endif

    // Store dropped by reset landing on its access edge
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 64'h10;
    bus.req_funct3 = 3'b011;
    bus.req_wdata  = 64'hCAFEF00DCAFEF00D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid-reset req_ready", 64'(bus.req_ready), 64'd1);
    check("mid-reset resp_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_req("ld after rst", 1'b0, 64'h10, 3'b011, 64'h0, 0, r, e);
    check("ld after rst const", r, 64'h1122334480667788);

    do_req("sd 0x1010", 1'b1, 64'h1010, 3'b011, 64'h0123456789ABCDEF, 0, r, e);
    do_req("ld 0x010 alias", 1'b0, 64'h010, 3'b011, 64'h0, 0, r, e);
    check("alias const", r, 64'h0123456789ABCDEF);

    for (int i = 0; i < 16; i++) begin
      do_req("rand init", 1'b1, 64'h100 + 64'(8*i), 3'b011, {$urandom, $urandom}, 0, r, e);
    end
    for (int i = 0; i < 60; i++) begin
      a        = {$urandom, $urandom};
      a[11:0]  = 12'h100 + 12'($urandom_range(0, 127));
      do_req("rand", 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)),
             {$urandom, $urandom}, int'($urandom_range(0, 2)), r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
